// File: rtl/conv_window_addr_gen_if.sv
// Tap-address stream from conv_window_addr_gen to the feature-memory read port.
// The addr_pad signal exists only when CONV_PAD_EN is defined.
interface conv_window_addr_gen_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic [5:0]        tap_idx;
  logic              win_first;
  logic              win_last;
`ifdef CONV_PAD_EN
  logic              addr_pad;
`endif

  modport master (
    output addr, addr_valid, tap_idx, win_first, win_last,
`ifdef CONV_PAD_EN
    output addr_pad,
`endif
    input  addr_ready
  );

  modport slave (
    input  addr, addr_valid, tap_idx, win_first, win_last,
`ifdef CONV_PAD_EN
    input  addr_pad,
`endif
    output addr_ready
  );
endinterface

// File: rtl/conv_window_addr_gen.sv
// KxK convolution window tap-address generator over a row-major frame, stride STRIDE.
// Optional "same" padding via CONV_PAD_EN (adds addr_pad on the stream interface).
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | presenting taps, advancing on valid & ready
//   S_DONE | one-cycle frame_done, then back to idle
module conv_window_addr_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic frame_done,
  output logic mem_init,
  conv_window_addr_gen_if.master rd
);

`ifdef CONV_PAD_EN
  localparam int P = K / 2;
`else
  localparam int P = 0;
`endif
  localparam int OUT_W = (IMG_W + 2*P - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2*P - K) / STRIDE + 1;
  localparam int DIM   = (IMG_W > IMG_H ? IMG_W : IMG_H) + 2*P + 1;
  localparam int CW    = $clog2(DIM) + 1;

  localparam logic [2:0]        K_LAST    = 3'(K - 1);
  localparam logic [5:0]        TAP_LAST  = 6'(K*K - 1);
  localparam logic [CW-1:0]     WX_LAST   = CW'(OUT_W - 1);
  localparam logic [CW-1:0]     WY_LAST   = CW'(OUT_H - 1);
  // Linear address arithmetic is modulo 2^ADDR_W; the negative padded origin
  // wraps, and every in-bounds tap still lands on its exact address.
  localparam logic [ADDR_W-1:0] ORIGIN    = ADDR_W'(-(P*IMG_W + P));
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WIN_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] WROW_STEP = ADDR_W'(STRIDE*IMG_W);

`ifdef CONV_PAD_EN
  localparam int SW = CW + 1;
  localparam logic signed [SW-1:0] C_ORG  = SW'(-P);
  localparam logic signed [SW-1:0] C_ONE  = SW'(1);
  localparam logic signed [SW-1:0] C_STEP = SW'(STRIDE);
  localparam logic signed [SW-1:0] W_LIM  = SW'(IMG_W);
  localparam logic signed [SW-1:0] H_LIM  = SW'(IMG_H);
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [2:0]        kx_q, ky_q, t_kx, t_ky;
  logic [CW-1:0]     wx_q, wy_q, t_wx, t_wy;
  logic [5:0]        tap_q, t_tap;
  logic [ADDR_W-1:0] lin_q, rowb_q, winb_q, wrowb_q;
  logic [ADDR_W-1:0] t_lin, t_rowb, t_winb, t_wrowb;
  logic [ADDR_W-1:0] addr_q;
  logic              first_q, last_q;
  logic              valid_c, hs, last_tap, load_en, t_pad;
`ifdef CONV_PAD_EN
  logic signed [SW-1:0] col_q, row_q, wcol_q, wrow_q;
  logic signed [SW-1:0] t_col, t_row, t_wcol, t_wrow;
  logic                 pad_q;
`endif

  assign hs      = valid_c & rd.addr_ready;
  assign load_en = ((state_q == S_IDLE) & start) | ((state_q == S_RUN) & hs & ~last_tap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (hs && last_tap) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    valid_c    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_RUN: begin
        busy    = 1'b1;
        valid_c = 1'b1;
      end
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // Target values for the next tap: frame origin from IDLE, otherwise the
  // scan successor (kx fastest, then ky, then window column, then window row).
  always_comb begin
    last_tap = 1'b0;
    t_kx    = kx_q;
    t_ky    = ky_q;
    t_wx    = wx_q;
    t_wy    = wy_q;
    t_tap   = tap_q;
    t_lin   = lin_q;
    t_rowb  = rowb_q;
    t_winb  = winb_q;
    t_wrowb = wrowb_q;
`ifdef CONV_PAD_EN
    t_col  = col_q;
    t_row  = row_q;
    t_wcol = wcol_q;
    t_wrow = wrow_q;
`endif
    if (state_q == S_IDLE) begin
      t_kx    = '0;
      t_ky    = '0;
      t_wx    = '0;
      t_wy    = '0;
      t_tap   = '0;
      t_lin   = ORIGIN;
      t_rowb  = ORIGIN;
      t_winb  = ORIGIN;
      t_wrowb = ORIGIN;
`ifdef CONV_PAD_EN
      t_col  = C_ORG;
      t_row  = C_ORG;
      t_wcol = C_ORG;
      t_wrow = C_ORG;
`endif
    end else if (kx_q != K_LAST) begin
      t_kx  = kx_q + 3'd1;
      t_tap = tap_q + 6'd1;
      t_lin = lin_q + ONE_A;
`ifdef CONV_PAD_EN
      t_col = col_q + C_ONE;
`endif
    end else if (ky_q != K_LAST) begin
      t_kx   = '0;
      t_ky   = ky_q + 3'd1;
      t_tap  = tap_q + 6'd1;
      t_rowb = rowb_q + ROW_STEP;
      t_lin  = rowb_q + ROW_STEP;
`ifdef CONV_PAD_EN
      t_col = wcol_q;
      t_row = row_q + C_ONE;
`endif
    end else if (wx_q != WX_LAST) begin
      t_kx   = '0;
      t_ky   = '0;
      t_tap  = '0;
      t_wx   = wx_q + CW'(1);
      t_winb = winb_q + WIN_STEP;
      t_rowb = winb_q + WIN_STEP;
      t_lin  = winb_q + WIN_STEP;
`ifdef CONV_PAD_EN
      t_wcol = wcol_q + C_STEP;
      t_col  = wcol_q + C_STEP;
      t_row  = wrow_q;
`endif
    end else if (wy_q != WY_LAST) begin
      t_kx    = '0;
      t_ky    = '0;
      t_tap   = '0;
      t_wx    = '0;
      t_wy    = wy_q + CW'(1);
      t_wrowb = wrowb_q + WROW_STEP;
      t_winb  = wrowb_q + WROW_STEP;
      t_rowb  = wrowb_q + WROW_STEP;
      t_lin   = wrowb_q + WROW_STEP;
`ifdef CONV_PAD_EN
      t_wcol = C_ORG;
      t_col  = C_ORG;
      t_wrow = wrow_q + C_STEP;
      t_row  = wrow_q + C_STEP;
`endif
    end else begin
      last_tap = 1'b1;
    end
`ifdef CONV_PAD_EN
    t_pad = t_col[SW-1] || (t_col >= W_LIM) || t_row[SW-1] || (t_row >= H_LIM);
`else
    t_pad = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kx_q    <= '0;
      ky_q    <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      tap_q   <= '0;
      lin_q   <= '0;
      rowb_q  <= '0;
      winb_q  <= '0;
      wrowb_q <= '0;
      addr_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef CONV_PAD_EN
      col_q  <= '0;
      row_q  <= '0;
      wcol_q <= '0;
      wrow_q <= '0;
      pad_q  <= 1'b0;
`endif
    end else if (load_en) begin
      kx_q    <= t_kx;
      ky_q    <= t_ky;
      wx_q    <= t_wx;
      wy_q    <= t_wy;
      tap_q   <= t_tap;
      lin_q   <= t_lin;
      rowb_q  <= t_rowb;
      winb_q  <= t_winb;
      wrowb_q <= t_wrowb;
      addr_q  <= t_pad ? '0 : t_lin;
      first_q <= (t_tap == '0);
      last_q  <= (t_tap == TAP_LAST);
`ifdef CONV_PAD_EN
      col_q  <= t_col;
      row_q  <= t_row;
      wcol_q <= t_wcol;
      wrow_q <= t_wrow;
      pad_q  <= t_pad;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          mem_init <= 1'b0;
    else if ((state_q == S_IDLE) && start) mem_init <= 1'b1;
  end

  assign rd.addr       = addr_q;
  assign rd.addr_valid = valid_c;
  assign rd.tap_idx    = tap_q;
  assign rd.win_first  = first_q;
  assign rd.win_last   = last_q;
`ifdef CONV_PAD_EN
  assign rd.addr_pad   = pad_q;
`endif

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: three geometries checked tap by tap against
// a window-coordinate model, with random back-pressure and mid-frame reset.
module tb_conv_window_addr_gen;
  localparam int KK = 3;
`ifdef CONV_PAD_EN
  localparam int PAD = KK / 2;
`else
  localparam int PAD = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic start_s [3];
  logic rdy     [3];

  logic [19:0] o_addr  [3];
  logic [5:0]  o_tap   [3];
  logic        o_valid [3];
  logic        o_first [3];
  logic        o_last  [3];
  logic        o_busy  [3];
  logic        o_done  [3];
  logic        o_init  [3];
`ifdef CONV_PAD_EN
  logic        o_pad   [3];
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  conv_window_addr_gen_if #(.ADDR_W(20)) if_a ();
  conv_window_addr_gen_if #(.ADDR_W(5))  if_b ();
  conv_window_addr_gen_if #(.ADDR_W(5))  if_c ();

  conv_window_addr_gen #(.IMG_W(640), .IMG_H(480), .K(KK), .STRIDE(1), .ADDR_W(20)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .busy(o_busy[0]),
    .frame_done(o_done[0]), .mem_init(o_init[0]), .rd(if_a));
  conv_window_addr_gen #(.IMG_W(5), .IMG_H(4), .K(KK), .STRIDE(1), .ADDR_W(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .busy(o_busy[1]),
    .frame_done(o_done[1]), .mem_init(o_init[1]), .rd(if_b));
  conv_window_addr_gen #(.IMG_W(5), .IMG_H(5), .K(KK), .STRIDE(2), .ADDR_W(5)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_s[2]), .busy(o_busy[2]),
    .frame_done(o_done[2]), .mem_init(o_init[2]), .rd(if_c));

  assign if_a.addr_ready = rdy[0];
  assign if_b.addr_ready = rdy[1];
  assign if_c.addr_ready = rdy[2];

  assign o_addr[0] = if_a.addr;
  assign o_addr[1] = 20'(if_b.addr);
  assign o_addr[2] = 20'(if_c.addr);
  assign o_tap[0] = if_a.tap_idx;
  assign o_tap[1] = if_b.tap_idx;
  assign o_tap[2] = if_c.tap_idx;
  assign o_valid[0] = if_a.addr_valid;
  assign o_valid[1] = if_b.addr_valid;
  assign o_valid[2] = if_c.addr_valid;
  assign o_first[0] = if_a.win_first;
  assign o_first[1] = if_b.win_first;
  assign o_first[2] = if_c.win_first;
  assign o_last[0] = if_a.win_last;
  assign o_last[1] = if_b.win_last;
  assign o_last[2] = if_c.win_last;
`ifdef CONV_PAD_EN
  assign o_pad[0] = if_a.addr_pad;
  assign o_pad[1] = if_b.addr_pad;
  assign o_pad[2] = if_c.addr_pad;
`endif

  function automatic int img_w(input int d);
    return (d == 0) ? 640 : 5;
  endfunction
  function automatic int img_h(input int d);
    return (d == 0) ? 480 : ((d == 1) ? 4 : 5);
  endfunction
  function automatic int strd(input int d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int out_w(input int d);
    return (img_w(d) + 2*PAD - KK) / strd(d) + 1;
  endfunction
  function automatic int out_h(input int d);
    return (img_h(d) + 2*PAD - KK) / strd(d) + 1;
  endfunction
  function automatic int flen(input int d);
    return out_w(d) * out_h(d) * KK * KK;
  endfunction

  // Handshake n decomposed into window/tap coordinates, then addressed in image space.
  function automatic void model(input int d, input int n, output int a, output int pad, output int tap);
    int kx, ky, wx, wy, r, c;
    kx  = n % KK;
    ky  = (n / KK) % KK;
    wx  = (n / (KK*KK)) % out_w(d);
    wy  = n / (KK*KK*out_w(d));
    r   = wy*strd(d) - PAD + ky;
    c   = wx*strd(d) - PAD + kx;
    pad = (r < 0 || r >= img_h(d) || c < 0 || c >= img_w(d)) ? 1 : 0;
    a   = (pad != 0) ? 0 : r*img_w(d) + c;
    tap = ky*KK + kx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input int d, input string tag);
    chk({tag, "_addr"},  o_addr[d],  0);
    chk({tag, "_valid"}, o_valid[d], 0);
    chk({tag, "_busy"},  o_busy[d],  0);
    chk({tag, "_tap"},   o_tap[d],   0);
    chk({tag, "_first"}, o_first[d], 0);
    chk({tag, "_last"},  o_last[d],  0);
    chk({tag, "_done"},  o_done[d],  0);
    chk({tag, "_init"},  o_init[d],  0);
  endtask

  task automatic run_frame(input int d, input int stall_pct, input bit poke, input bit hold,
                           input int max_taps, input int abort_at);
    int lim, fl, n, cyc, ea, ep, et;
    bit stalled, aborted;
    fl = flen(d);
    lim = (max_taps < fl) ? max_taps : fl;
    n = 0; cyc = 0; stalled = 0; aborted = 0;
    rdy[d] = 1'b0;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = hold;
    chk("busy_on_start", o_busy[d], 1);
    chk("mem_init_set", o_init[d], 1);
    while (n < lim && cyc < 4000) begin
      if (abort_at >= 0 && n == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_idle_zero(d, "abort");
        chk("abort_other_valid", o_valid[2], 0);
        rdy[d] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        aborted = 1;
        break;
      end
      model(d, n, ea, ep, et);
      chk("valid", o_valid[d], 1);
      chk("busy", o_busy[d], 1);
      chk("done_low", o_done[d], 0);
      chk(stalled ? "addr_stalled" : "addr", o_addr[d], ea);
      chk(stalled ? "tap_stalled" : "tap", o_tap[d], et);
      chk("win_first", o_first[d], (et == 0));
      chk("win_last", o_last[d], (et == KK*KK-1));
`ifdef CONV_PAD_EN
      chk("addr_pad", o_pad[d], ep);
`endif
      rdy[d] = ($urandom_range(99) >= stall_pct);
      if (poke) start_s[d] = ($urandom_range(3) == 0);
      else      start_s[d] = hold;
      if (rdy[d]) begin
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      @(negedge clk);
      cyc++;
    end
    rdy[d] = 1'b0;
    start_s[d] = hold;
    if (!aborted) begin
      if (n < lim) begin
        n_checks++;
        n_err++;
        $display("FAIL timeout dut=%0d handshakes=%0d required=%0d", d, n, lim);
      end else if (lim == fl) begin
        chk("frame_done_pulse", o_done[d], 1);
        chk("busy_after_frame", o_busy[d], 0);
        chk("valid_after_frame", o_valid[d], 0);
        @(negedge clk);
        chk("frame_done_once", o_done[d], 0);
        chk("busy_idle", o_busy[d], 0);
        if (hold) begin
          @(negedge clk);
          model(d, 0, ea, ep, et);
          chk("restart_valid", o_valid[d], 1);
          chk("restart_addr", o_addr[d], ea);
          start_s[d] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      rdy[i]     = 1'b0;
    end
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle_zero(i, "reset");
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("idle_no_start", o_busy[i], 0);

    run_frame(1, 0, 1'b0, 1'b0, 1000, -1);
    run_frame(1, 30, 1'b1, 1'b0, 1000, -1);
    run_frame(2, 0, 1'b0, 1'b1, 1000, -1);
    run_frame(0, 0, 1'b0, 1'b0, 1000, 20);
    run_frame(0, 20, 1'b0, 1'b0, 30, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_window_addr_gen.md
Name: conv_window_addr_gen

Overview:
- Generates read addresses for every KxK convolution window over an IMG_W x IMG_H row-major frame buffer, at a programmable stride.
- Feeds the feature-memory read port ahead of the conv MAC array, one tap address per accepted handshake.
- Replaces the fixed 3x3 / 640-wide window-offset sequencer with a parametrised, back-pressurable, frame-aware generator.

Parameters:
- IMG_W, 640, frame width in pixels (>= K)
- IMG_H, 480, frame height in pixels (>= K)
- K, 3, kernel size (odd, 1..7)
- STRIDE, 1, window step in both axes (1..K)
- ADDR_W, 20, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  frame start request, sampled only in IDLE
- busy  out  1  high from accepted start until frame end
- addr  out  ADDR_W  current tap address
- addr_valid  out  1  addr and side-band outputs valid
- addr_ready  in  1  consumer accepts the tap when valid & ready
- tap_idx  out  6  tap number in window, ky*K+kx
- win_first  out  1  tap_idx==0
- win_last  out  1  tap_idx==K*K-1
- frame_done  out  1  one-cycle pulse at frame end
- mem_init  out  1  sticky; set on first accepted start, cleared only by reset

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM in IDLE, all counters 0.
- FSM states and transitions:
  - IDLE: start=1 -> RUN; busy=1 and addr_valid=1 with tap 0 of window 0 on the next cycle (1-cycle latency).
  - RUN: advance only on valid&ready; after the final handshake -> DONE.
  - DONE: single cycle; frame_done=1, busy=0, addr_valid=0; -> IDLE.
- Derived constants: OUT_W=(IMG_W-K)/STRIDE+1, OUT_H=(IMG_H-K)/STRIDE+1, integer floor. Frame length = OUT_W*OUT_H*K*K handshakes.
- Scan order: kx fastest, then ky, then window column, then window row.
- addr = win_base + ky*IMG_W + kx, with win_base = wy*STRIDE*IMG_W + wx*STRIDE.
  - Computed incrementally with registered row/window bases; no multipliers.
  - addr is registered.
- Wrap-around rules:
  - kx wraps at K-1 -> ky++.
  - ky wraps at K-1 -> next window: wx++, base += STRIDE.
  - wx wraps at OUT_W-1 -> wy++, row base += STRIDE*IMG_W.
  - Last tap of window (OUT_W-1, OUT_H-1) ends the frame.
- Backpressure: while addr_valid=1 and addr_ready=0, addr, tap_idx, win_first and win_last hold stable. addr_valid never drops without a handshake.
- start while busy or in DONE: ignored, no queueing.
- start held high continuously: a new frame begins in the cycle after DONE.
- mem_init: set on the clock edge that accepts the first start after reset.
- Reset mid-frame: immediate abort to IDLE, outputs 0, mem_init cleared.

Optional Feature:
- Macro: CONV_PAD_EN.
- Defined:
  - "same" padding of P=K/2 on all sides; OUT_W=(IMG_W+2P-K)/STRIDE+1, OUT_H likewise.
  - Window origin is offset by -P in both axes.
  - Adds output port addr_pad (1 bit). Taps falling outside the image assert addr_pad=1 with addr=0, and are still handshaken.
  - Bounds are checked with signed row/column counters, not address compare.
- Undefined: no padding; addr_pad port absent; behaviour as above.

Test Plan:
- Defaults (640x480, K=3, S=1), start pulse -> first nine handshakes give 0,1,2,640,641,642,1280,1281,1282; second window starts at 1; win_first/win_last on taps 0/8.
- IMG_W=5, IMG_H=4, K=3, S=1, addr_ready=1 -> exactly 54 handshakes; last window is 7,8,9,12,13,14,17,18,19; frame_done pulses once, the cycle after the 54th handshake; busy then 0.
- IMG_W=5, IMG_H=5, S=2 -> 4 windows; second window is 2,3,4,7,8,9,12,13,14; third window starts at 10.
- Random addr_ready with 30% low duty -> addr stable while stalled; sequence identical to the no-stall run; start pulses during RUN ignored.
- Assert reset_n mid-frame at handshake 20 -> outputs 0 immediately, mem_init=0; new start replays from addr 0.
- CONV_PAD_EN, IMG_W=4, IMG_H=4, K=3 -> 16 windows; window 0 taps 0-3 and 6 have addr_pad=1; tap 4 is addr 0, tap 5 addr 1, tap 7 addr 4, tap 8 addr 5.
